rob_circ: RTL and testbench

- Parametrised successor to the 32-entry reorder buffer, built as a circular buffer of DEPTH entries.
- The ROB allocates tags itself. A tag is the entry index at tail, so there is no external tag pool.
- Provides dispatch backpressure, CDB writeback, tag-indexed operand lookup, in-order single retire with store handshake, and flush on a taken branch at retire.
- Sits between dispatch and the ARF/store path. The external register status table uses dispatch_tag and retire_rd_tag.

---
 rtl/rob_circ_if.sv | 66 ++++++
 rtl/rob_circ.sv | 132 +++++++++++++
 tb/tb_rob_circ.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rob_circ_if.sv
// Dispatch / CDB / lookup / retire bundle of the circular reorder buffer.
// The ROB connects through the slave modport. The dispatch/CDB/store side connects through the master modport.
interface rob_circ_if #(
    parameter int DEPTH  = 32,
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int PC_W   = 32
);
    localparam int TAG_W = $clog2(DEPTH);

    // dispatch
    logic              dispatch_valid;
    logic              dispatch_ready;
    logic [TAG_W-1:0]  dispatch_tag;
    logic [REG_W-1:0]  dispatch_rd_reg;
    logic [PC_W-1:0]   dispatch_pc;
    logic [1:0]        dispatch_inst_type;

    // common data bus writeback
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic              cdb_branch_taken;

    // operand lookup
    logic [TAG_W-1:0]  rs_tag;
    logic [TAG_W-1:0]  rt_tag;
    logic              rs_data_valid;
    logic              rt_data_valid;
    logic [DATA_W-1:0] rs_data_spec;
    logic [DATA_W-1:0] rt_data_spec;

    // retire / store handshake / flush
    logic              retire_valid;
    logic              arf_retire_valid;
    logic              flush_valid;
    logic              retire_store_ready;
    logic              retire_store_ack;
    logic [TAG_W-1:0]  retire_rd_tag;
    logic [REG_W-1:0]  retire_rd_reg;
    logic [DATA_W-1:0] retire_data;
    logic [PC_W-1:0]   retire_pc;
    logic [TAG_W:0]    occupancy;

    modport slave (
        input  dispatch_valid, dispatch_rd_reg, dispatch_pc, dispatch_inst_type,
        output dispatch_ready, dispatch_tag,
        input  cdb_valid, cdb_tag, cdb_data, cdb_branch_taken,
        input  rs_tag, rt_tag,
        output rs_data_valid, rt_data_valid, rs_data_spec, rt_data_spec,
        input  retire_store_ack,
        output retire_valid, arf_retire_valid, flush_valid, retire_store_ready,
        output retire_rd_tag, retire_rd_reg, retire_data, retire_pc, occupancy
    );

    modport master (
        output dispatch_valid, dispatch_rd_reg, dispatch_pc, dispatch_inst_type,
        input  dispatch_ready, dispatch_tag,
        output cdb_valid, cdb_tag, cdb_data, cdb_branch_taken,
        output rs_tag, rt_tag,
        input  rs_data_valid, rt_data_valid, rs_data_spec, rt_data_spec,
        output retire_store_ack,
        input  retire_valid, arf_retire_valid, flush_valid, retire_store_ready,
        input  retire_rd_tag, retire_rd_reg, retire_data, retire_pc, occupancy
    );
endinterface

// File: rtl/rob_circ.sv
// Circular reorder buffer: self-allocated tags, CDB writeback, operand lookup, in-order retire, store ack, branch flush.
// Latency: dispatch at edge N, CDB at edge N+1, retire visible in cycle N+1; lookups combinational (same-cycle CDB bypass with ROB_BYPASS_EN).
// Backpressure: dispatch_ready drops when full (no same-cycle retire credit); stores hold at head until retire_store_ack.
module rob_circ #(
    parameter int DEPTH  = 32,
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int PC_W   = 32
) (
    input  logic        clock,
    input  logic        nreset,
    rob_circ_if.slave   bus
);
    localparam int TAG_W = $clog2(DEPTH);

    localparam logic [1:0] TYPE_ALU    = 2'd0;
    localparam logic [1:0] TYPE_BRANCH = 2'd1;
    localparam logic [1:0] TYPE_STORE  = 2'd2;

    typedef logic [TAG_W-1:0] tag_t;
    typedef logic [TAG_W:0]   cnt_t;

    // entry status (reset) and payload (no reset; only read behind valid/done)
    logic [DEPTH-1:0]  ent_valid;
    logic [DEPTH-1:0]  ent_done;
    logic [DEPTH-1:0]  ent_taken;
    logic [1:0]        ent_type [DEPTH];
    logic [REG_W-1:0]  ent_reg  [DEPTH];
    logic [PC_W-1:0]   ent_pc   [DEPTH];
    logic [DATA_W-1:0] ent_data [DEPTH];

    tag_t head;
    tag_t tail;
    cnt_t count;

    logic       head_ready;
    logic       head_is_store;
    logic       retire_fire;
    logic       flush_fire;
    logic       alloc_fire;
    logic       cdb_hit;
    logic       wb_fire;
    logic       not_full;
    logic [1:0] head_type;

    always_comb begin
        head_type     = ent_type[head];
        head_ready    = ent_valid[head] && ent_done[head];
        head_is_store = (head_type == TYPE_STORE);
        retire_fire   = head_ready && (!head_is_store || bus.retire_store_ack);
        flush_fire    = retire_fire && (head_type == TYPE_BRANCH) && ent_taken[head];
        not_full      = (count != cnt_t'(DEPTH));
        alloc_fire    = bus.dispatch_valid && not_full && !flush_fire;
        cdb_hit       = bus.cdb_valid && ent_valid[bus.cdb_tag];
        wb_fire       = cdb_hit && !flush_fire;
    end

    always_comb begin
        bus.dispatch_ready     = not_full;
        bus.dispatch_tag       = tail;
        bus.occupancy          = count;
        bus.retire_valid       = retire_fire;
        bus.arf_retire_valid   = retire_fire && (head_type == TYPE_ALU);
        bus.flush_valid        = flush_fire;
        bus.retire_store_ready = head_ready && head_is_store;
        bus.retire_rd_tag      = head;
        bus.retire_rd_reg      = ent_reg[head];
        bus.retire_data        = ent_data[head];
        bus.retire_pc          = ent_pc[head];
    end

    always_comb begin
        bus.rs_data_valid = ent_valid[bus.rs_tag] && ent_done[bus.rs_tag];
        bus.rs_data_spec  = ent_data[bus.rs_tag];
        bus.rt_data_valid = ent_valid[bus.rt_tag] && ent_done[bus.rt_tag];
        bus.rt_data_spec  = ent_data[bus.rt_tag];
`ifdef ROB_BYPASS_EN
        // forward a result landing this cycle so consumers need not wait an edge
        if (cdb_hit && (bus.cdb_tag == bus.rs_tag)) begin
            bus.rs_data_valid = 1'b1;
            bus.rs_data_spec  = bus.cdb_data;
        end
        if (cdb_hit && (bus.cdb_tag == bus.rt_tag)) begin
            bus.rt_data_valid = 1'b1;
            bus.rt_data_spec  = bus.cdb_data;
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (!nreset) begin
            ent_valid <= '0;
            ent_done  <= '0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
        end else if (flush_fire) begin
            // everything younger than the taken branch is wrong-path
            ent_valid <= '0;
            ent_done  <= '0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
        end else begin
            if (wb_fire) begin
                ent_done[bus.cdb_tag] <= 1'b1;
            end
            if (retire_fire) begin
                ent_valid[head] <= 1'b0;
            end
            if (alloc_fire) begin
                ent_valid[tail] <= 1'b1;
                ent_done[tail]  <= 1'b0;
            end
            head  <= head + tag_t'(retire_fire);
            tail  <= tail + tag_t'(alloc_fire);
            count <= count + cnt_t'(alloc_fire) - cnt_t'(retire_fire);
        end
    end

    always_ff @(posedge clock) begin
        if (alloc_fire) begin
            ent_type[tail] <= bus.dispatch_inst_type;
            ent_reg[tail]  <= bus.dispatch_rd_reg;
            ent_pc[tail]   <= bus.dispatch_pc;
        end
        if (wb_fire) begin
            ent_data[bus.cdb_tag]  <= bus.cdb_data;
            ent_taken[bus.cdb_tag] <= bus.cdb_branch_taken;
        end
    end
endmodule

// File: tb/tb_rob_circ.sv
// Bench for rob_circ (DEPTH=8): directed scenarios with literal expectations, then random traffic,
// with a queue-based in-order model compared against the DUT on every negedge.
module tb_rob_circ;
    localparam int DEPTH  = 8;
    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int PC_W   = 32;
`ifdef ROB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clock = 1'b0;
    logic nreset = 1'b0;
    always #5 clock = ~clock;

    rob_circ_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .REG_W(REG_W), .PC_W(PC_W)) bus ();

    rob_circ #(.DEPTH(DEPTH), .DATA_W(DATA_W), .REG_W(REG_W), .PC_W(PC_W)) dut (
        .clock  (clock),
        .nreset (nreset),
        .bus    (bus)
    );

    typedef struct {
        int                tag;
        int                typ;
        logic [REG_W-1:0]  rd;
        logic [PC_W-1:0]   pc;
        bit                done;
        bit                taken;
        logic [DATA_W-1:0] data;
    } ment_t;

    ment_t q[$];
    int    next_tag = 0;
    bit    mdl_on   = 1'b0;
    int    n_chk    = 0;
    int    n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int find(input int tag);
        for (int i = 0; i < q.size(); i++)
            if (q[i].tag == tag) return i;
        return -1;
    endfunction

    task automatic look(input int tag, output bit v, output logic [DATA_W-1:0] d);
        int idx;
        idx = find(tag);
        v = (idx >= 0) && q[idx].done;
        d = v ? q[idx].data : '0;
        if (BYP && bus.cdb_valid && (find(int'(bus.cdb_tag)) >= 0) && (int'(bus.cdb_tag) == tag)) begin
            v = 1'b1;
            d = bus.cdb_data;
        end
    endtask

    // model: oldest-first queue; compare current cycle, then advance to the next edge
    always @(negedge clock) begin : mdl
        int sz, idx;
        bit h, rv, fl, lv;
        logic [DATA_W-1:0] ld;
        ment_t e;
        sz = q.size();
        h  = (sz > 0) && q[0].done;
        rv = h && ((q[0].typ != 2) || bus.retire_store_ack);
        fl = rv && (q[0].typ == 1) && q[0].taken;
        if (mdl_on) begin
            chk("m_dispatch_ready", bus.dispatch_ready, sz < DEPTH);
            chk("m_dispatch_tag", bus.dispatch_tag, next_tag);
            chk("m_occupancy", bus.occupancy, sz);
            chk("m_retire_valid", bus.retire_valid, rv);
            chk("m_arf_retire_valid", bus.arf_retire_valid, rv && (q[0].typ == 0));
            chk("m_flush_valid", bus.flush_valid, fl);
            chk("m_store_ready", bus.retire_store_ready, h && (q[0].typ == 2));
            if (rv) begin
                chk("m_retire_rd_tag", bus.retire_rd_tag, q[0].tag);
                chk("m_retire_rd_reg", bus.retire_rd_reg, q[0].rd);
                chk("m_retire_data", bus.retire_data, q[0].data);
                chk("m_retire_pc", bus.retire_pc, q[0].pc);
            end
            look(int'(bus.rs_tag), lv, ld);
            chk("m_rs_valid", bus.rs_data_valid, lv);
            if (lv) chk("m_rs_data", bus.rs_data_spec, ld);
            look(int'(bus.rt_tag), lv, ld);
            chk("m_rt_valid", bus.rt_data_valid, lv);
            if (lv) chk("m_rt_data", bus.rt_data_spec, ld);
        end
        if (!nreset || fl) begin
            q.delete();
            next_tag = 0;
        end else begin
            if (bus.cdb_valid) begin
                idx = find(int'(bus.cdb_tag));
                if (idx >= 0) begin
                    e = q[idx];
                    e.done = 1'b1;
                    e.data = bus.cdb_data;
                    e.taken = bus.cdb_branch_taken;
                    q[idx] = e;
                end
            end
            if (rv) void'(q.pop_front());
            if (bus.dispatch_valid && (sz < DEPTH)) begin
                e.tag = next_tag;
                e.typ = int'(bus.dispatch_inst_type);
                e.rd = bus.dispatch_rd_reg;
                e.pc = bus.dispatch_pc;
                e.done = 1'b0;
                e.taken = 1'b0;
                e.data = '0;
                q.push_back(e);
                next_tag = (next_tag + 1) % DEPTH;
            end
        end
    end

    task automatic idle();
        bus.dispatch_valid     = 1'b0;
        bus.dispatch_rd_reg    = '0;
        bus.dispatch_pc        = '0;
        bus.dispatch_inst_type = 2'd0;
        bus.cdb_valid          = 1'b0;
        bus.cdb_tag            = '0;
        bus.cdb_data           = '0;
        bus.cdb_branch_taken   = 1'b0;
        bus.rs_tag             = '0;
        bus.rt_tag             = '0;
        bus.retire_store_ack   = 1'b0;
    endtask

    task automatic adv();
        @(posedge clock);
        #1;
        idle();
    endtask

    task automatic smp();
        @(negedge clock);
    endtask

    task automatic disp(input int typ);
        bus.dispatch_valid     = 1'b1;
        bus.dispatch_inst_type = typ[1:0];
        bus.dispatch_rd_reg    = REG_W'($urandom_range(0, 31));
        bus.dispatch_pc        = $urandom;
    endtask

    task automatic cdb(input int tag, input logic [DATA_W-1:0] d, input bit tk);
        bus.cdb_valid        = 1'b1;
        bus.cdb_tag          = tag[2:0];
        bus.cdb_data         = d;
        bus.cdb_branch_taken = tk;
    endtask

    task automatic do_reset();
        nreset = 1'b0;
        smp();
        adv();
        nreset = 1'b1;
    endtask

    initial begin
        idle();
        nreset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        nreset = 1'b1;
        mdl_on = 1'b1;

        // reset state
        smp();
        chk("rst_ready", bus.dispatch_ready, 1);
        chk("rst_tag", bus.dispatch_tag, 0);
        chk("rst_occ", bus.occupancy, 0);
        chk("rst_retire", bus.retire_valid, 0);
        chk("rst_flush", bus.flush_valid, 0);
        chk("rst_rs_valid", bus.rs_data_valid, 0);
        adv();

        // three ALU ops, out-of-order completion, in-order retire
        for (int i = 0; i < 3; i++) begin
            disp(0); smp(); chk("t1_tag", bus.dispatch_tag, i); adv();
        end
        cdb(1, 32'h111, 1'b0); smp(); chk("t1_occ", bus.occupancy, 3); chk("t1_rv0", bus.retire_valid, 0); adv();
        cdb(0, 32'h100, 1'b0); smp(); chk("t1_rv_wait", bus.retire_valid, 0); adv();
        smp(); chk("t1_rv_a", bus.retire_valid, 1); chk("t1_tag_a", bus.retire_rd_tag, 0);
        chk("t1_data_a", bus.retire_data, 32'h100); chk("t1_arf_a", bus.arf_retire_valid, 1); adv();
        smp(); chk("t1_rv_b", bus.retire_valid, 1); chk("t1_tag_b", bus.retire_rd_tag, 1);
        chk("t1_data_b", bus.retire_data, 32'h111); adv();
        smp(); chk("t1_hold", bus.retire_valid, 0); chk("t1_occ_end", bus.occupancy, 1); adv();
        do_reset();

        // fill, ignored dispatch while full, no same-cycle credit, wrap
        for (int i = 0; i < DEPTH; i++) begin
            disp(0); smp(); chk("t2_tag", bus.dispatch_tag, i); adv();
        end
        disp(0); smp(); chk("t2_full_ready", bus.dispatch_ready, 0); chk("t2_full_occ", bus.occupancy, 8); adv();
        smp(); chk("t2_ign_occ", bus.occupancy, 8); chk("t2_wrap_tag", bus.dispatch_tag, 0); adv();
        cdb(0, 32'hA5A5, 1'b0); adv();
        smp(); chk("t2_rv", bus.retire_valid, 1); chk("t2_nocredit", bus.dispatch_ready, 0); adv();
        disp(0); smp(); chk("t2_ready", bus.dispatch_ready, 1); chk("t2_occ7", bus.occupancy, 7);
        chk("t2_tag0", bus.dispatch_tag, 0); adv();
        smp(); chk("t2_refull", bus.dispatch_ready, 0); chk("t2_occ8", bus.occupancy, 8); adv();
        do_reset();

        // store handshake
        disp(2); adv();
        cdb(0, 32'h55, 1'b0); adv();
        smp(); chk("t3_st_rdy", bus.retire_store_ready, 1); chk("t3_rv0", bus.retire_valid, 0); adv();
        smp(); chk("t3_st_hold", bus.retire_store_ready, 1); chk("t3_rv0b", bus.retire_valid, 0); adv();
        bus.retire_store_ack = 1'b1;
        smp(); chk("t3_rv", bus.retire_valid, 1); chk("t3_arf", bus.arf_retire_valid, 0); adv();
        smp(); chk("t3_occ", bus.occupancy, 0); chk("t3_st_gone", bus.retire_store_ready, 0); adv();
        do_reset();

        // taken branch at head flushes, same-cycle dispatch/CDB dropped
        disp(1); adv();
        for (int i = 0; i < 3; i++) begin disp(0); adv(); end
        for (int i = 1; i < 4; i++) begin cdb(i, 32'h10 + i, 1'b0); adv(); end
        cdb(0, 32'hB0, 1'b1); adv();
        disp(0); cdb(1, 32'h77, 1'b0);
        smp(); chk("t4_flush", bus.flush_valid, 1); chk("t4_rv", bus.retire_valid, 1); chk("t4_occ4", bus.occupancy, 4); adv();
        smp(); chk("t4_occ0", bus.occupancy, 0); chk("t4_tag0", bus.dispatch_tag, 0); chk("t4_ready", bus.dispatch_ready, 1); adv();
        do_reset();

        // CDB-to-lookup visibility
        for (int i = 0; i < 6; i++) begin disp(0); adv(); end
        cdb(5, 32'hDEADBEEF, 1'b0); bus.rs_tag = 3'd5; bus.rt_tag = 3'd5;
        smp(); chk("t5_rs_same", bus.rs_data_valid, BYP); chk("t5_rt_same", bus.rt_data_valid, BYP); adv();
        bus.rs_tag = 3'd5;
        smp(); chk("t5_rs_next", bus.rs_data_valid, 1); chk("t5_rs_data", bus.rs_data_spec, 32'hDEADBEEF); adv();
        do_reset();

        // reset wins over a pending store ack
        disp(2); adv(); disp(0); adv(); disp(0); cdb(0, 32'h9, 1'b0); adv();
        nreset = 1'b0; bus.retire_store_ack = 1'b1;
        smp(); chk("t6_st_rdy", bus.retire_store_ready, 1); chk("t6_occ3", bus.occupancy, 3); adv();
        nreset = 1'b1; bus.rs_tag = 3'd1;
        smp(); chk("t6_occ0", bus.occupancy, 0); chk("t6_st", bus.retire_store_ready, 0);
        chk("t6_rv", bus.retire_valid, 0); chk("t6_rs", bus.rs_data_valid, 0); adv();

        // random traffic against the model
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 399) == 0) nreset = 1'b0;
            else nreset = 1'b1;
            if ($urandom_range(0, 99) < 55) disp(int'($urandom_range(0, 3)));
            if ($urandom_range(0, 99) < 60) begin
                if ((q.size() > 0) && ($urandom_range(0, 3) != 0))
                    cdb(q[$urandom_range(0, q.size() - 1)].tag, $urandom, $urandom_range(0, 3) == 0);
                else
                    cdb(int'($urandom_range(0, DEPTH - 1)), $urandom, $urandom_range(0, 3) == 0);
            end
            bus.retire_store_ack = 1'($urandom_range(0, 1));
            bus.rs_tag = 3'($urandom_range(0, DEPTH - 1));
            bus.rt_tag = 3'($urandom_range(0, DEPTH - 1));
            adv();
        end
        nreset = 1'b1;
        smp();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
